idex_skid_stage: RTL and testbench
==================================

IDEX_SKID_STAGE -- requirements
Module: idex_skid_stage

Interface
REQ-001 Parameter PAYLOAD_W, default 112: width of the decoded-instruction payload (aluop, reg1, reg2, wd, wreg, link address, inst) as one packed bus.
REQ-002 Parameter SKID, default 1: 1 selects a 2-entry skid buffer, 0 selects a single-register stage.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kill all held entries; synchronous.
REQ-007 in_valid  input  1  ID presents a valid payload.
REQ-008 in_ready  output  1  stage accepts the payload this cycle.
REQ-009 in_payload  input  PAYLOAD_W  ID payload.
REQ-010 in_ds  input  1  the entry is in a delay slot.
REQ-011 in_next_ds  input  1  the next instruction is in a delay slot.
REQ-012 out_valid  output  1  EX-side payload is valid.
REQ-013 out_ready  input  1  EX consumes the payload this cycle.
REQ-014 out_payload  output  PAYLOAD_W  payload presented to EX.
REQ-015 out_ds  output  1  delay-slot flag of the presented entry.
REQ-016 ds_fb  output  1  registered copy of in_next_ds from the last accepted entry, fed back to ID.
REQ-017 stall_cnt  output  CNT_W  count of back-pressure cycles.

Function
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-019 The stage SHALL be FIFO-ordered, with payload, in_ds and in_next_ds travelling together; no entry SHALL be dropped or duplicated except by flush.
REQ-020 SKID=1 state machine SHALL use the states EMPTY, ONE (main valid) and TWO (main and skid valid).
REQ-021 EMPTY: input transfer -> ONE.
REQ-022 ONE:
  - input without output -> TWO (new entry into skid);
  - output without input -> EMPTY;
  - both -> ONE (main replaced).
REQ-023 TWO: output transfer -> ONE (skid moves to main); no input is possible in TWO.
REQ-024 SKID=1: in_ready SHALL equal !(state==TWO), driven from a register with no combinational path from out_ready.
REQ-025 SKID=0: in_ready SHALL equal !out_valid || out_ready (combinational), with a single entry.
REQ-026 Latency: an accepted entry SHALL appear on out_* the cycle after acceptance when the stage was EMPTY or draining; throughput SHALL be 1 entry/cycle when out_ready is held high.
REQ-027 out_payload, out_ds and out_valid SHALL come directly from the main register.
REQ-028 ds_fb SHALL update only on an input transfer.
REQ-029 flush SHALL force the state to EMPTY next cycle and SHALL take precedence over a simultaneous input or output transfer; the flushed payload register contents are don't-care, but out_valid SHALL be 0.
REQ-030 flush SHALL clear ds_fb to 0.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with out_valid && !out_ready && !flush, saturate at all-ones and never wrap; only rst clears it.

Reset
REQ-032 While rst=1, every output SHALL be 0 on the next edge: out_valid, out_payload, out_ds, ds_fb, stall_cnt and internal skid valid; state = EMPTY.
REQ-033 in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-034 rst SHALL take precedence over flush and over all transfers, including mid-operation in state TWO; held entries are discarded.

Verification
REQ-035 Streaming: SKID=1, out_ready=1, push payloads 1,2,3 on consecutive cycles -> out_payload shows 1,2,3 on cycles +1..+3, in_ready constant 1, stall_cnt=0.
REQ-036 Back-pressure: out_ready=0, push A then B -> state TWO, in_ready=0 on cycle 3; raise out_ready for 2 cycles -> outputs A then B, in_ready returns 1, stall_cnt=2.
REQ-037 Flush in TWO: flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, ds_fb=0, stall_cnt unchanged.
REQ-038 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-039 Reset mid-operation: state TWO with in_next_ds=1 accepted, assert rst one cycle -> all outputs 0, then in_ready=1.
REQ-040 SKID=0: out_ready=0 with an entry held -> in_ready=0; out_ready=1 and in_valid=1 in the same cycle -> entry replaced, in_ready=1.

Source files
------------

// File: rtl/idex_skid_stage.sv
// ---------------------------------------------------------------------------
// idex_skid_stage
// ID -> EX pipeline register with optional two-entry skid buffer.
//
// Decoded-instruction payload, its delay-slot flag and the "next is in a
// delay slot" flag travel together in FIFO order.
//
// SKID=1 : two entries (main + skid). in_ready comes straight from a
//          register, so there is no combinational path from out_ready.
// SKID=0 : single entry. in_ready = !out_valid || out_ready.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           discard every held entry; clears ds_fb
//   in_valid/ready  ID-side handshake
//   in_payload      decoded instruction bundle (PAYLOAD_W bits)
//   in_ds           entry sits in a delay slot
//   in_next_ds      the instruction after this entry is in a delay slot
//   out_valid/ready EX-side handshake
//   out_payload     bundle presented to EX (from the main register)
//   out_ds          delay-slot flag of the presented entry
//   ds_fb           in_next_ds of the last accepted entry, fed back to ID
//   stall_cnt       saturating count of back-pressured cycles
// ---------------------------------------------------------------------------
module idex_skid_stage #(
  parameter int PAYLOAD_W = 112,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_ds,
  input  logic                 in_next_ds,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_ds,
  output logic                 ds_fb,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] main_payload_p1;
  logic                 main_ds_p1;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = vld_p1 && out_ready;
  assign out_valid   = vld_p1;
  assign out_payload = main_payload_p1;
  assign out_ds      = main_ds_p1;

  generate
    if (SKID != 0) begin : g_skid
      state_t               state_q;
      state_t               state_nxt;
      logic                 rdy_q;
      logic [PAYLOAD_W-1:0] skid_payload_p1;
      logic                 skid_ds_p1;
      logic                 ld_main_in;
      logic                 ld_main_skid;
      logic                 ld_skid;

      assign in_ready = rdy_q;
      assign vld_p1   = (state_q != EMPTY);

      always_comb begin
        state_nxt    = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              state_nxt  = ONE;
              ld_main_in = 1'b1;
            end
          end
          ONE: begin
            if (in_xfer && !out_xfer) begin
              state_nxt = TWO;
              ld_skid   = 1'b1;
            end else if (!in_xfer && out_xfer) begin
              state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
              ld_main_in = 1'b1;
            end
          end
          TWO: begin
            if (out_xfer) begin
              state_nxt    = ONE;
              ld_main_skid = 1'b1;
            end
          end
          default: state_nxt = EMPTY;
        endcase
        // Payload registers may still load under flush; their contents are
        // irrelevant once the state says EMPTY.
        if (flush) state_nxt = EMPTY;
      end

      // ---- stage p1: main + skid registers ----
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q         <= EMPTY;
          rdy_q           <= 1'b1;
          main_payload_p1 <= '0;
          main_ds_p1      <= 1'b0;
          skid_payload_p1 <= '0;
          skid_ds_p1      <= 1'b0;
        end else begin
          state_q <= state_nxt;
          // Ready is precomputed from next state so it leaves a flop.
          rdy_q   <= (state_nxt != TWO);
          if (ld_main_in) begin
            main_payload_p1 <= in_payload;
            main_ds_p1      <= in_ds;
          end else if (ld_main_skid) begin
            main_payload_p1 <= skid_payload_p1;
            main_ds_p1      <= skid_ds_p1;
          end
          if (ld_skid) begin
            skid_payload_p1 <= in_payload;
            skid_ds_p1      <= in_ds;
          end
        end
      end
    end else begin : g_single
      logic vld_q;

      assign vld_p1   = vld_q;
      assign in_ready = !vld_q || out_ready;

      // ---- stage p1: single register ----
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q           <= 1'b0;
          main_payload_p1 <= '0;
          main_ds_p1      <= 1'b0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (in_xfer) begin
          vld_q           <= 1'b1;
          main_payload_p1 <= in_payload;
          main_ds_p1      <= in_ds;
        end else if (out_xfer) begin
          vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_fb     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        ds_fb <= 1'b0;
      end else if (in_xfer) begin
        ds_fb <= in_next_ds;
      end
      if (vld_p1 && !out_ready && !flush) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_skid_stage
// Drives a SKID=1 and a SKID=0 instance (both CNT_W=4) from the same inputs.
// Each instance has a queue-based reference model: capacity rules for
// ready, FIFO order for data, a plain integer for the stall counter.
// ---------------------------------------------------------------------------
module tb_idex_skid_stage;
  localparam int PW   = 112;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, in_ds, in_next_ds, out_ready;
  logic [PW-1:0] in_payload;

  logic          in_ready1, out_valid1, out_ds1, ds_fb1;
  logic [PW-1:0] out_payload1;
  logic [CW-1:0] stall1;
  logic          in_ready0, out_valid0, out_ds0, ds_fb0;
  logic [PW-1:0] out_payload0;
  logic [CW-1:0] stall0;

  idex_skid_stage #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(CW)) u_skid1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_payload(in_payload), .in_ds(in_ds), .in_next_ds(in_next_ds),
    .out_valid(out_valid1), .out_ready(out_ready), .out_payload(out_payload1),
    .out_ds(out_ds1), .ds_fb(ds_fb1), .stall_cnt(stall1));

  idex_skid_stage #(.PAYLOAD_W(PW), .SKID(0), .CNT_W(CW)) u_skid0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_payload(in_payload), .in_ds(in_ds), .in_next_ds(in_next_ds),
    .out_valid(out_valid0), .out_ready(out_ready), .out_payload(out_payload0),
    .out_ds(out_ds0), .ds_fb(ds_fb0), .stall_cnt(stall0));

  typedef struct packed {
    logic [PW-1:0] p;
    logic          ds;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  logic fb1 = 1'b0, fb0 = 1'b0;
  int   st1 = 0, st0 = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [PW-1:0] p, input logic ds,
                       input logic nds, input logic ordy, input logic fl, input logic r);
    in_valid   = iv;
    in_payload = p;
    in_ds      = ds;
    in_next_ds = nds;
    out_ready  = ordy;
    flush      = fl;
    rst        = r;
  endtask

  // One clock: check ready before the edge, advance the models, check outputs after.
  task automatic step();
    logic r1, r0, ix1, ix0, ox1, ox0;
    ent_t e;
    #1;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    if (!rst) begin
      chk("in_ready_skid1", in_ready1, r1);
      chk("in_ready_skid0", in_ready0, r0);
    end
    ix1 = in_valid && r1;
    ix0 = in_valid && r0;
    ox1 = (q1.size() > 0) && out_ready;
    ox0 = (q0.size() > 0) && out_ready;
    e.p  = in_payload;
    e.ds = in_ds;
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete();
      fb1 = 1'b0; fb0 = 1'b0;
      st1 = 0; st0 = 0;
    end else begin
      if (q1.size() > 0 && !out_ready && !flush && st1 < CMAX) st1++;
      if (q0.size() > 0 && !out_ready && !flush && st0 < CMAX) st0++;
      if (flush) begin
        q1.delete(); q0.delete();
        fb1 = 1'b0; fb0 = 1'b0;
      end else begin
        if (ox1) void'(q1.pop_front());
        if (ix1) begin q1.push_back(e); fb1 = in_next_ds; end
        if (ox0) void'(q0.pop_front());
        if (ix0) begin q0.push_back(e); fb0 = in_next_ds; end
      end
    end
    #1;
    chk("out_valid_skid1", out_valid1, q1.size() > 0);
    if (q1.size() > 0) begin
      chk("out_payload_skid1", out_payload1, q1[0].p);
      chk("out_ds_skid1", out_ds1, q1[0].ds);
    end
    chk("ds_fb_skid1", ds_fb1, fb1);
    chk("stall_skid1", stall1, st1);
    chk("out_valid_skid0", out_valid0, q0.size() > 0);
    if (q0.size() > 0) begin
      chk("out_payload_skid0", out_payload0, q0[0].p);
      chk("out_ds_skid0", out_ds0, q0[0].ds);
    end
    chk("ds_fb_skid0", ds_fb0, fb0);
    chk("stall_skid0", stall0, st0);
  endtask

  initial begin
    logic [127:0] rnd;
    logic [CW-1:0] st_saved;

    // Reset
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk("rst_payload1", out_payload1, 128'h0);
    chk("rst_ds1", out_ds1, 1'b0);
    chk("rst_payload0", out_payload0, 128'h0);

    // First cycle after reset: ready must be up
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_ready1", in_ready1, 1'b1);
    step();

    // Streaming 1,2,3 with out_ready held high
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, PW'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("stream_payload1", out_payload1, 128'(i));
      chk("stream_ready1", in_ready1, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("stream_stall1", stall1, 4'd0);

    // Back-pressure: A then B into the skid pair, then drain
    drive(1'b1, PW'('hA), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_single_ready0", in_ready0, 1'b0);
    drive(1'b1, PW'('hB), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_two_ready1", in_ready1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_head_A", out_payload1, 128'hA);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_head_B", out_payload1, 128'hB);
    step();
    chk("bp_stall1", stall1, 4'd2);
    chk("bp_ready_back1", in_ready1, 1'b1);

    // Single-register replacement with out_ready and in_valid together
    drive(1'b1, PW'('hC), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'('hD), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("replace_payload0", out_payload0, 128'hD);
    chk("replace_ready0", in_ready0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();

    // Flush while holding two entries, with a push in the same cycle
    drive(1'b1, PW'('hE), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, PW'('hF), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    st_saved = CW'(st1);
    drive(1'b1, PW'('h99), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("flush_valid1", out_valid1, 1'b0);
    chk("flush_ready1", in_ready1, 1'b1);
    chk("flush_ds_fb1", ds_fb1, 1'b0);
    chk("flush_stall1", stall1, st_saved);

    // Saturation from a clean counter
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, PW'('h5A), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall1", stall1, 4'd15);
    chk("sat_stall0", stall0, 4'd15);

    // Reset while two entries are held and ds_fb is set
    drive(1'b1, PW'('h11), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_rst_ds_fb1", ds_fb1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("midrst_valid1", out_valid1, 1'b0);
    chk("midrst_payload1", out_payload1, 128'h0);
    chk("midrst_ds1", out_ds1, 1'b0);
    chk("midrst_ds_fb1", ds_fb1, 1'b0);
    chk("midrst_stall1", stall1, 4'd0);
    chk("midrst_ready1", in_ready1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(1, 0)), rnd[PW-1:0], 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0),
            ($urandom_range(15, 0) == 0), ($urandom_range(63, 0) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
